temporizador_regressivo: RTL
============================

# temporizador_regressivo

Programmable down-counting timer, the decrementing counterpart of the team's 74163-style up counter. It loads a preset, counts down to zero one step per enabled clock, signals completion with a one-cycle pulse, and can pause, restart or auto-reload. It sits in the datapath next to the up counters and is driven by the control unit for timeouts and fixed-length waits. Its borrow output allows cascading for wider delays.

## Interface
- WIDTH, 4, width of preset and count value

- clock  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous and active-low; forces all state and outputs to reset values immediately
- iniciar  in  1  start/restart strobe, sampled every edge, active-high
- pausar  in  1  pause request, level, active-high
- recarga  in  1  auto-reload mode, level, sampled in FIM
- ent  in  1  count enable (cascade input), active-high
- D  in  WIDTH  preset value, sampled when loading
- Q  out  WIDTH  current count (registered)
- rbo  out  1  ripple borrow out: combinational, ent && (Q == 0)
- fim  out  1  completion pulse, high exactly one cycle per expiry
- ocupado  out  1  high in CONTANDO and PAUSADO
- db_estado  out  2  state code: PARADO=00, CONTANDO=01, PAUSADO=10, FIM=11

## Operation
- Reset (clr=0): state PARADO, Q=0, fim=0, ocupado=0, db_estado=00. rbo then equals ent. Reset mid-count discards progress; no fim is issued.
- Load rule, used wherever "load" appears: Q<=D. If D==0, next state is FIM. Otherwise next state is CONTANDO.
- Priority in every state: iniciar, then pausar, then counting.
- PARADO: Q holds. iniciar=1 -> load. pausar and ent are ignored.
- CONTANDO:
  - iniciar=1 -> load (restart).
  - Else pausar=1 -> PAUSADO, Q holds.
  - Else ent=1 -> Q<=Q-1. If Q==1, next state is FIM.
  - Else Q holds and the state stays CONTANDO.
- PAUSADO:
  - iniciar=1 -> load.
  - Else pausar=0 -> CONTANDO. No decrement on the resume edge.
  - Q holds throughout.
- FIM: Q=0 and fim=1 for this single cycle.
  - Next edge: iniciar=1 or recarga=1 -> load.
  - Otherwise -> PARADO.
- Arithmetic: unsigned WIDTH-bit. Q never wraps below 0; the FIM transition prevents it.
- fim and ocupado are Moore outputs decoded from the state register.

## Timing
- Preset N>=1, ent=1 held, no pause: the iniciar edge E0 loads N. Q reaches 0 at edge E0+N, the same edge that enters FIM. fim is high during the cycle after E0+N. PARADO is entered at E0+N+1 (or a reload if recarga=1).
- Total iniciar-to-fim latency: N+1 edges. Every cycle with ent=0 or in PAUSADO adds one cycle.
- D==0: fim is high in the cycle after the iniciar edge.
- Auto-reload with constant ent=1 and D=N: fim period is N+1 cycles.
- iniciar asserted in the same cycle as fim (state FIM): reloads. No PARADO cycle occurs and no extra fim is produced.
- rbo is combinational from Q and ent, with no register delay. Cascading: the upper stage's ent is the lower stage's rbo.

## Test plan
- Basic count: reset, D=5, iniciar pulse, ent=1 -> Q steps 5,4,3,2,1,0. fim is high exactly 1 cycle, 6 edges after iniciar. Then db_estado=00 and ocupado=0.
- Pause/resume: D=8, pausar=1 while Q=4 for 3 cycles -> Q holds 4 and db_estado=10. Release -> Q=3 one edge after the resume edge. fim is 4 cycles later than in the unpaused case.
- Enable gating and borrow: D=3, ent toggled 1,0,1,0,... -> Q decrements only on ent=1 edges. rbo=1 only when ent=1 and Q=0.
- Auto-reload: recarga=1, D=2, ent=1 -> fim pulses every 3 cycles with Q pattern 2,1,0,2,1,0. Drop recarga -> PARADO after the next fim.
- Restart and zero preset: iniciar again at Q=2 with D=6 -> Q=6 and counting continues. D=0 with iniciar -> fim in the next cycle and Q stays 0.
- Async reset mid-count: D=9, assert clr=0 between edges at Q=5 -> Q=0, db_estado=00, ocupado=0 immediately, with no fim. After release -> idle until iniciar.

Source files
------------

// File: rtl/temporizador_regressivo.sv
// Programmable down-counting timer: load a preset, count to zero, pulse fim.
// Latency: N+1 edges from iniciar to the fim cycle (plus one per ent=0 or paused cycle).
// Backpressure: none; ent gates counting and pausar holds it, and rbo cascades to the next stage.
//
// Ports:
//   clock      rising-edge system clock
//   clr        asynchronous active-low reset
//   iniciar    start/restart strobe (highest priority)
//   pausar     pause request level
//   recarga    auto-reload mode, honoured in FIM
//   ent        count enable / cascade input
//   D          preset value, sampled on load
//   Q          current count (registered)
//   rbo        ripple borrow: ent && (Q == 0), combinational
//   fim        one-cycle completion pulse (state FIM)
//   ocupado    high in CONTANDO and PAUSADO
//   db_estado  state code: PARADO=00, CONTANDO=01, PAUSADO=10, FIM=11
module temporizador_regressivo #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             iniciar,
    input  logic             pausar,
    input  logic             recarga,
    input  logic             ent,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rbo,
    output logic             fim,
    output logic             ocupado,
    output logic [1:0]       db_estado
);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        FIM      = 2'b11
    } estado_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            estado_q <= PARADO;
            cnt_q    <= ZERO;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // A load of zero skips counting entirely and goes straight to FIM, so
    // CONTANDO is never entered with a zero count and Q cannot wrap.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        unique case (estado_q)
            PARADO: begin
                if (iniciar) begin
                    cnt_d    = D;
                    estado_d = (D == ZERO) ? FIM : CONTANDO;
                end
            end
            CONTANDO: begin
                if (iniciar) begin
                    cnt_d    = D;
                    estado_d = (D == ZERO) ? FIM : CONTANDO;
                end else if (pausar) begin
                    estado_d = PAUSADO;
                end else if (ent) begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        estado_d = FIM;
                    end
                end
            end
            PAUSADO: begin
                // Resume edge only changes state; decrementing restarts next edge.
                if (iniciar) begin
                    cnt_d    = D;
                    estado_d = (D == ZERO) ? FIM : CONTANDO;
                end else if (!pausar) begin
                    estado_d = CONTANDO;
                end
            end
            FIM: begin
                if (iniciar || recarga) begin
                    cnt_d    = D;
                    estado_d = (D == ZERO) ? FIM : CONTANDO;
                end else begin
                    estado_d = PARADO;
                end
            end
            default: begin
                estado_d = PARADO;
                cnt_d    = ZERO;
            end
        endcase
    end

    assign Q         = cnt_q;
    assign rbo       = ent && (cnt_q == ZERO);
    assign fim       = (estado_q == FIM);
    assign ocupado   = (estado_q == CONTANDO) || (estado_q == PAUSADO);
    assign db_estado = estado_q;

endmodule
